// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the hardwired control unit: opcodes, ALU select codes,
// sequencer states and IR field positions. CU_MULDIV_EN enables mul/div decode.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SHR = 4'd4;
    localparam logic [3:0] ALU_SHL = 4'd5;
    localparam logic [3:0] ALU_ROR = 4'd6;
    localparam logic [3:0] ALU_ROL = 4'd7;
    localparam logic [3:0] ALU_MUL = 4'd8;
    localparam logic [3:0] ALU_DIV = 4'd9;
    localparam logic [3:0] ALU_NEG = 4'd10;
    localparam logic [3:0] ALU_NOT = 4'd11;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;
    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = 19;
    localparam int RC_MSB = 18;
    localparam int RC_LSB = 15;

    typedef enum logic [3:0] {
        ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_UNDEF, CLS_TWO, CLS_UNARY, CLS_MULDIV, CLS_NOP, CLS_HALT
    } op_class_t;

    // Anything not listed here (including mul/div when disabled) is undefined.
    function automatic op_class_t classify(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_SHR, OP_SHL,
            OP_ROR, OP_ROL, OP_AND, OP_OR: return CLS_TWO;
            OP_NEG, OP_NOT:                return CLS_UNARY;
`ifdef CU_MULDIV_EN
            OP_MUL, OP_DIV:                return CLS_MULDIV;
`endif
            OP_NOP:                        return CLS_NOP;
            OP_HALT:                       return CLS_HALT;
            default:                       return CLS_UNDEF;
        endcase
    endfunction

    function automatic logic [3:0] alu_code(input logic [4:0] op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_SHR:  return ALU_SHR;
            OP_SHL:  return ALU_SHL;
            OP_ROR:  return ALU_ROR;
            OP_ROL:  return ALU_ROL;
            OP_MUL:  return ALU_MUL;
            OP_DIV:  return ALU_DIV;
            OP_NEG:  return ALU_NEG;
            OP_NOT:  return ALU_NOT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/reg_select_encode.sv
// Turns the Gra/Grb/Grc field select plus Rin/Rout enables into one-hot
// register load and bus-drive vectors; a single shared index keeps each one-hot.
module reg_select_encode (
    input  logic [3:0]  ra,
    input  logic [3:0]  rb,
    input  logic [3:0]  rc,
    input  logic        gra,
    input  logic        grb,
    input  logic        grc,
    input  logic        rin,
    input  logic        rout,
    output logic [15:0] rin_sel,
    output logic [15:0] rout_sel
);

    logic [3:0]  reg_idx;
    logic [15:0] one_hot;

    always_comb begin
        reg_idx = 4'd0;
        if (gra)
            reg_idx = ra;
        else if (grb)
            reg_idx = rb;
        else if (grc)
            reg_idx = rc;
        one_hot  = 16'h0001 << reg_idx;
        rin_sel  = rin  ? one_hot : 16'h0000;
        rout_sel = rout ? one_hot : 16'h0000;
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired fetch/execute sequencer driving data_path strobes (T0-T6).
// Define CU_MULDIV_EN to decode mul/div and build the T6 state.
module control_unit
    import cpu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stop,
    input  logic [31:0] IR,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        ZIn,
    output logic        ZLowout,
    output logic        ZHighout,
    output logic        PCin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        HIin,
    output logic        LOin,
    output logic [15:0] Rin_sel,
    output logic [15:0] Rout_sel,
    output logic [3:0]  ALUselect,
    output logic        Run,
    output logic        ill_op
);

    state_t     state;
    logic       stop_flag;
    op_class_t  op_class;
    logic [3:0] op_alu;
    logic       instr_done;
    logic       gra, grb, grc, rin, rout;
    logic       unused_ir;

    assign op_class  = classify(IR[OP_MSB:OP_LSB]);
    assign op_alu    = alu_code(IR[OP_MSB:OP_LSB]);
    assign unused_ir = ^IR[RC_LSB-1:0];

    // Last execute state of each instruction class; the next edge re-enters T0.
    always_comb begin
        instr_done = 1'b0;
        case (state)
            ST_T3: instr_done = (op_class == CLS_NOP) || (op_class == CLS_UNDEF);
            ST_T4: instr_done = (op_class == CLS_UNARY);
            ST_T5: instr_done = (op_class == CLS_TWO);
`ifdef CU_MULDIV_EN
            ST_T6: instr_done = (op_class == CLS_MULDIV);
`endif
            default: instr_done = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_RST;
            stop_flag <= 1'b0;
        end else begin
            if (stop)
                stop_flag <= 1'b1;
            if (instr_done) begin
                if (stop_flag) begin
                    state     <= ST_HALT;
                    stop_flag <= 1'b0;
                end else begin
                    state <= ST_T0;
                end
            end else begin
                case (state)
                    ST_RST:  state <= ST_T0;
                    ST_T0:   state <= ST_T1;
                    ST_T1:   state <= ST_T2;
                    ST_T2:   state <= ST_T3;
                    ST_T3:   state <= (op_class == CLS_HALT) ? ST_HALT : ST_T4;
                    ST_T4:   state <= ST_T5;
`ifdef CU_MULDIV_EN
                    ST_T5:   state <= ST_T6;
`endif
                    ST_HALT: state <= ST_HALT;
                    default: state <= ST_RST;
                endcase
            end
        end
    end

    always_comb begin
        {PCout, MARin, IncPC, ZIn, ZLowout, ZHighout, PCin} = '0;
        {Read, MDRin, MDRout, IRin, Yin, HIin, LOin}        = '0;
        {gra, grb, grc, rin, rout} = '0;
        ALUselect = ALU_ADD;
        ill_op    = 1'b0;
        Run       = (state != ST_RST) && (state != ST_HALT);
        case (state)
            ST_T0: {PCout, MARin, IncPC, ZIn} = 4'b1111;
            ST_T1: {ZLowout, PCin, Read, MDRin} = 4'b1111;
            ST_T2: {MDRout, IRin} = 2'b11;
            ST_T3: begin
                case (op_class)
                    CLS_TWO:    begin grb = 1'b1; rout = 1'b1; Yin = 1'b1; end
                    CLS_UNARY:  begin grb = 1'b1; rout = 1'b1; ZIn = 1'b1; ALUselect = op_alu; end
                    CLS_MULDIV: begin gra = 1'b1; rout = 1'b1; Yin = 1'b1; end
                    CLS_UNDEF:  ill_op = 1'b1;
                    default:    ;
                endcase
            end
            ST_T4: begin
                case (op_class)
                    CLS_TWO:    begin grc = 1'b1; rout = 1'b1; ZIn = 1'b1; ALUselect = op_alu; end
                    CLS_UNARY:  begin ZLowout = 1'b1; gra = 1'b1; rin = 1'b1; end
                    CLS_MULDIV: begin grb = 1'b1; rout = 1'b1; ZIn = 1'b1; ALUselect = op_alu; end
                    default:    ;
                endcase
            end
            ST_T5: begin
                case (op_class)
                    CLS_TWO:    begin ZLowout = 1'b1; gra = 1'b1; rin = 1'b1; end
                    CLS_MULDIV: begin ZLowout = 1'b1; LOin = 1'b1; end
                    default:    ;
                endcase
            end
`ifdef CU_MULDIV_EN
            ST_T6: begin
                if (op_class == CLS_MULDIV) begin
                    ZHighout = 1'b1;
                    HIin     = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    reg_select_encode u_reg_select (
        .ra       (IR[RA_MSB:RA_LSB]),
        .rb       (IR[RB_MSB:RB_LSB]),
        .rc       (IR[RC_MSB:RC_LSB]),
        .gra      (gra),
        .grb      (grb),
        .grc      (grc),
        .rin      (rin),
        .rout     (rout),
        .rin_sel  (Rin_sel),
        .rout_sel (Rout_sel)
    );

endmodule

// File: tb/tb_control_unit.sv
// Directed scoreboard bench for control_unit; expected strobe vectors are queued
// with each stimulus step and compared one edge later. Honours CU_MULDIV_EN.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        reset, stop;
    logic [31:0] IR;
    logic        PCout, MARin, IncPC, ZIn, ZLowout, ZHighout, PCin;
    logic        Read, MDRin, MDRout, IRin, Yin, HIin, LOin;
    logic [15:0] Rin_sel, Rout_sel;
    logic [3:0]  ALUselect;
    logic        Run, ill_op;

    int checks = 0;
    int errors = 0;
    logic [51:0] exp_q[$];

    // Strobe bit positions in the packed expectation, PCout is the MSB.
    localparam logic [13:0] S_PCOUT  = 14'h2000;
    localparam logic [13:0] S_MARIN  = 14'h1000;
    localparam logic [13:0] S_INCPC  = 14'h0800;
    localparam logic [13:0] S_ZIN    = 14'h0400;
    localparam logic [13:0] S_ZLOW   = 14'h0200;
    localparam logic [13:0] S_ZHIGH  = 14'h0100;
    localparam logic [13:0] S_PCIN   = 14'h0080;
    localparam logic [13:0] S_READ   = 14'h0040;
    localparam logic [13:0] S_MDRIN  = 14'h0020;
    localparam logic [13:0] S_MDROUT = 14'h0010;
    localparam logic [13:0] S_IRIN   = 14'h0008;
    localparam logic [13:0] S_YIN    = 14'h0004;
    localparam logic [13:0] S_HIIN   = 14'h0002;
    localparam logic [13:0] S_LOIN   = 14'h0001;

    localparam logic [31:0] IR_AND  = 32'h4A920000;
    localparam logic [31:0] IR_MUL  = 32'h78900000;
    localparam logic [31:0] IR_NEG  = 32'h88A00000;
    localparam logic [31:0] IR_HALT = 32'hD8000000;
    localparam logic [31:0] IR_ADD  = {5'b00011, 4'd3, 4'd1, 4'd2, 15'd0};
    localparam logic [31:0] IR_OR   = {5'b01010, 4'd6, 4'd7, 4'd8, 15'd0};
    localparam logic [31:0] IR_BAD  = {5'b11111, 4'd1, 4'd2, 4'd3, 15'd0};

    control_unit dut (
        .clk(clk), .reset(reset), .stop(stop), .IR(IR),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .ZIn(ZIn),
        .ZLowout(ZLowout), .ZHighout(ZHighout), .PCin(PCin), .Read(Read),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
        .HIin(HIin), .LOin(LOin), .Rin_sel(Rin_sel), .Rout_sel(Rout_sel),
        .ALUselect(ALUselect), .Run(Run), .ill_op(ill_op)
    );

    always #5 clk = ~clk;

    function automatic logic [51:0] ev(input logic [13:0] s, input logic [15:0] rin,
                                       input logic [15:0] rout, input logic [3:0] alu,
                                       input logic run, input logic ill);
        return {s, rin, rout, alu, run, ill};
    endfunction

    function automatic logic [15:0] oh(input int n);
        return 16'h0001 << n;
    endfunction

    task automatic checkOutput(input string tag);
        logic [51:0] obs, expv;
        obs = {PCout, MARin, IncPC, ZIn, ZLowout, ZHighout, PCin, Read, MDRin,
               MDRout, IRin, Yin, HIin, LOin, Rin_sel, Rout_sel, ALUselect, Run, ill_op};
        expv = exp_q.pop_front();
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive inputs for the current state, expect the outputs of the next one.
    task automatic applyStimulus(input logic rst, input logic stp, input logic [31:0] ir,
                                 input logic [51:0] expv, input string tag);
        reset = rst;
        stop  = stp;
        IR    = ir;
        exp_q.push_back(expv);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    logic [51:0] e_zero, e_t0, e_t1, e_t2, e_halt_t3, e_ill_t3;

    initial begin
        e_zero    = ev(14'h0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
        e_t0      = ev(S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0);
        e_t1      = ev(S_ZLOW | S_PCIN | S_READ | S_MDRIN, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0);
        e_t2      = ev(S_MDROUT | S_IRIN, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0);
        e_halt_t3 = ev(14'h0, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0);
        e_ill_t3  = ev(14'h0, 16'h0, 16'h0, 4'd0, 1'b1, 1'b1);
        reset = 1'b1;
        stop  = 1'b0;
        IR    = 32'h0;

        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 1'b0, 32'h0, e_zero, "reset_hold");
        applyStimulus(1'b0, 1'b0, IR_AND, e_t0, "first_t0");

        applyStimulus(1'b0, 1'b0, IR_AND, e_t1, "and_t1");
        applyStimulus(1'b0, 1'b0, IR_AND, e_t2, "and_t2");
        applyStimulus(1'b0, 1'b0, IR_AND, ev(S_YIN, 16'h0, 16'h0004, 4'd0, 1'b1, 1'b0), "and_t3");
        applyStimulus(1'b0, 1'b0, IR_AND, ev(S_ZIN, 16'h0, 16'h0010, 4'd2, 1'b1, 1'b0), "and_t4");
        applyStimulus(1'b0, 1'b0, IR_AND, ev(S_ZLOW, 16'h0020, 16'h0, 4'd0, 1'b1, 1'b0), "and_t5");
        applyStimulus(1'b0, 1'b0, IR_AND, e_t0, "and_next_t0");

        applyStimulus(1'b0, 1'b0, IR_AND, e_t1, "neg_t1");
        applyStimulus(1'b0, 1'b0, IR_NEG, e_t2, "neg_t2_ir_change");
        applyStimulus(1'b0, 1'b0, IR_NEG, ev(S_ZIN, 16'h0, 16'h0010, 4'd10, 1'b1, 1'b0), "neg_t3");
        applyStimulus(1'b0, 1'b0, IR_NEG, ev(S_ZLOW, 16'h0002, 16'h0, 4'd0, 1'b1, 1'b0), "neg_t4");
        applyStimulus(1'b0, 1'b0, IR_NEG, e_t0, "neg_next_t0");

        applyStimulus(1'b0, 1'b0, IR_MUL, e_t1, "mul_t1");
        applyStimulus(1'b0, 1'b0, IR_MUL, e_t2, "mul_t2");
`ifdef CU_MULDIV_EN
        applyStimulus(1'b0, 1'b0, IR_MUL, ev(S_YIN, 16'h0, 16'h0002, 4'd0, 1'b1, 1'b0), "mul_t3");
        applyStimulus(1'b0, 1'b0, IR_MUL, ev(S_ZIN, 16'h0, 16'h0004, 4'd8, 1'b1, 1'b0), "mul_t4");
        applyStimulus(1'b0, 1'b0, IR_MUL, ev(S_ZLOW | S_LOIN, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0), "mul_t5");
        applyStimulus(1'b0, 1'b0, IR_MUL, ev(S_ZHIGH | S_HIIN, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0), "mul_t6");
`else
        applyStimulus(1'b0, 1'b0, IR_MUL, e_ill_t3, "mul_ill_t3");
`endif
        applyStimulus(1'b0, 1'b0, IR_MUL, e_t0, "mul_next_t0");

        applyStimulus(1'b0, 1'b0, IR_BAD, e_t1, "bad_t1");
        applyStimulus(1'b0, 1'b0, IR_BAD, e_t2, "bad_t2");
        applyStimulus(1'b0, 1'b0, IR_BAD, e_ill_t3, "bad_ill_t3");
        applyStimulus(1'b0, 1'b0, IR_BAD, e_t0, "bad_next_t0");

        applyStimulus(1'b0, 1'b0, IR_ADD, e_t1, "add_t1");
        applyStimulus(1'b0, 1'b0, IR_ADD, e_t2, "add_t2");
        applyStimulus(1'b0, 1'b0, IR_ADD, ev(S_YIN, 16'h0, oh(1), 4'd0, 1'b1, 1'b0), "add_t3");
        applyStimulus(1'b0, 1'b0, IR_ADD, ev(S_ZIN, 16'h0, oh(2), 4'd0, 1'b1, 1'b0), "add_t4");
        applyStimulus(1'b0, 1'b1, IR_ADD, ev(S_ZLOW, oh(3), 16'h0, 4'd0, 1'b1, 1'b0), "add_t5_stop");
        applyStimulus(1'b0, 1'b0, IR_ADD, e_zero, "stop_halt");
        applyStimulus(1'b0, 1'b0, IR_ADD, e_zero, "stop_halt_hold");
        applyStimulus(1'b1, 1'b0, IR_OR, e_zero, "halt_reset");
        applyStimulus(1'b0, 1'b0, IR_OR, e_t0, "halt_restart_t0");

        applyStimulus(1'b0, 1'b0, IR_OR, e_t1, "or_t1");
        applyStimulus(1'b0, 1'b0, IR_OR, e_t2, "or_t2");
        applyStimulus(1'b0, 1'b0, IR_OR, ev(S_YIN, 16'h0, oh(7), 4'd0, 1'b1, 1'b0), "or_t3");
        applyStimulus(1'b0, 1'b0, IR_OR, ev(S_ZIN, 16'h0, oh(8), 4'd3, 1'b1, 1'b0), "or_t4");
        applyStimulus(1'b1, 1'b0, IR_OR, e_zero, "or_reset_mid");
        applyStimulus(1'b0, 1'b0, IR_HALT, e_t0, "or_reset_t0");

        applyStimulus(1'b0, 1'b0, IR_HALT, e_t1, "halt_t1");
        applyStimulus(1'b0, 1'b0, IR_HALT, e_t2, "halt_t2");
        applyStimulus(1'b0, 1'b0, IR_HALT, e_halt_t3, "halt_t3");
        applyStimulus(1'b0, 1'b0, IR_HALT, e_zero, "halt_state");
        applyStimulus(1'b0, 1'b1, IR_AND, e_zero, "halt_hold");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
